wb_regfile: RTL and testbench

- Writeback stage plus architectural register file of the 16-bit SIMPLE pipeline.
- Consumes the MEM/WB pipeline register outputs.
- Selects the destination register and the write data, then commits the write on the clock edge.
- Provides two combinational read ports to the decode stage and a commit counter for debug.

---
 rtl/simple_pkg.sv | 21 ++
 rtl/wb_select.sv | 28 ++
 rtl/wb_regfile.sv | 106 ++++++++++
 tb/tb_wb_regfile.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared constants, types and writeback select encodings for the 16-bit SIMPLE pipeline.
package simple_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic {
      WB_DST_RD = 1'b0,
      WB_DST_RS = 1'b1
   } wb_dst_e;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_select.sv
// Writeback destination/data mux; also reused by the hazard unit to derive the WB destination address.
module wb_select #(
   parameter int DATA_W = simple_pkg::DATA_W,
   parameter int ADDR_W = simple_pkg::ADDR_W
) (
   input  logic              op_reg_write_address_wb,
   input  logic              op_res_wb,
   input  logic [ADDR_W-1:0] rs_wb,
   input  logic [ADDR_W-1:0] rd_wb,
   input  logic [DATA_W-1:0] data_register_wb,
   input  logic [DATA_W-1:0] memory_data_register_wb,
   output logic [ADDR_W-1:0] wsel_addr,
   output logic [DATA_W-1:0] wsel_data
);
   import simple_pkg::*;

   always_comb begin
      wsel_addr = rd_wb;
      wsel_data = data_register_wb;
      if (op_reg_write_address_wb == WB_DST_RS) begin
         wsel_addr = rs_wb;
      end
      if (op_res_wb == WB_SRC_MEM) begin
         wsel_data = memory_data_register_wb;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: commit on posedge, two combinational read ports.
// Define WB_REGFILE_BYPASS_EN to forward the in-flight writeback data to matching read ports.
module wb_regfile #(
   parameter int DATA_W = simple_pkg::DATA_W,
   parameter int ADDR_W = simple_pkg::ADDR_W,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              op_reg_write_wb,
   input  logic              op_reg_write_address_wb,
   input  logic              op_res_wb,
   input  logic [ADDR_W-1:0] rs_wb,
   input  logic [ADDR_W-1:0] rd_wb,
   input  logic [DATA_W-1:0] data_register_wb,
   input  logic [DATA_W-1:0] memory_data_register_wb,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [CNT_W-1:0]  commit_count
);
   import simple_pkg::*;

   localparam int REG_COUNT = 2 ** ADDR_W;

   logic [ADDR_W-1:0] wsel_addr;
   logic [DATA_W-1:0] wsel_data;
   logic              commit;

   logic [DATA_W-1:0] regs_reg [REG_COUNT];
   logic              wb_valid_reg;
   logic [ADDR_W-1:0] wb_addr_reg;
   logic [DATA_W-1:0] wb_data_reg;
   logic [CNT_W-1:0]  commit_count_reg;
   logic [CNT_W-1:0]  commit_count_next;

   wb_select #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_wb_select (
      .op_reg_write_address_wb(op_reg_write_address_wb),
      .op_res_wb              (op_res_wb),
      .rs_wb                  (rs_wb),
      .rd_wb                  (rd_wb),
      .data_register_wb       (data_register_wb),
      .memory_data_register_wb(memory_data_register_wb),
      .wsel_addr              (wsel_addr),
      .wsel_data              (wsel_data)
   );

   // Select inputs only matter behind the enable, so X on them cannot disturb state.
   assign commit = op_reg_write_wb;

   generate
      for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
         always_ff @(posedge clock) begin
            if (!reset) begin
               regs_reg[gi] <= '0;
            end else if (commit && (wsel_addr == ADDR_W'(gi))) begin
               regs_reg[gi] <= wsel_data;
            end
         end
      end
   endgenerate

   assign commit_count_next = commit_count_reg + CNT_W'(1);

   always_ff @(posedge clock) begin
      if (!reset) begin
         wb_valid_reg     <= 1'b0;
         wb_addr_reg      <= '0;
         wb_data_reg      <= '0;
         commit_count_reg <= '0;
      end else if (commit) begin
         wb_valid_reg     <= 1'b1;
         wb_addr_reg      <= wsel_addr;
         wb_data_reg      <= wsel_data;
         commit_count_reg <= commit_count_next;
      end else begin
         wb_valid_reg     <= 1'b0;
      end
   end

   always_comb begin
      rd_data_a = regs_reg[rd_addr_a];
      rd_data_b = regs_reg[rd_addr_b];
`ifdef WB_REGFILE_BYPASS_EN
      if (reset && commit && (rd_addr_a == wsel_addr)) begin
         rd_data_a = wsel_data;
      end
      if (reset && commit && (rd_addr_b == wsel_addr)) begin
         rd_data_b = wsel_data;
      end
`endif
   end

   assign wb_valid     = wb_valid_reg;
   assign wb_addr      = wb_addr_reg;
   assign wb_data      = wb_data_reg;
   assign commit_count = commit_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a 4-bit commit counter keeps the wrap check short.
module tb_wb_regfile;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = 4;

   logic              clock;
   logic              reset;
   logic              op_reg_write_wb;
   logic              op_reg_write_address_wb;
   logic              op_res_wb;
   logic [ADDR_W-1:0] rs_wb;
   logic [ADDR_W-1:0] rd_wb;
   logic [DATA_W-1:0] data_register_wb;
   logic [DATA_W-1:0] memory_data_register_wb;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [CNT_W-1:0]  commit_count;

   int tests_run;
   int tests_failed;

   wb_regfile #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .op_reg_write_wb        (op_reg_write_wb),
      .op_reg_write_address_wb(op_reg_write_address_wb),
      .op_res_wb              (op_res_wb),
      .rs_wb                  (rs_wb),
      .rd_wb                  (rd_wb),
      .data_register_wb       (data_register_wb),
      .memory_data_register_wb(memory_data_register_wb),
      .rd_addr_a              (rd_addr_a),
      .rd_addr_b              (rd_addr_b),
      .rd_data_a              (rd_data_a),
      .rd_data_b              (rd_data_b),
      .wb_valid               (wb_valid),
      .wb_addr                (wb_addr),
      .wb_data                (wb_data),
      .commit_count           (commit_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one commit for one clock, then drop the enable.
   task automatic commit_rd(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
      op_reg_write_wb         = 1'b1;
      op_reg_write_address_wb = 1'b0;
      op_res_wb               = 1'b0;
      rd_wb                   = rd;
      data_register_wb        = d;
      tick();
      op_reg_write_wb         = 1'b0;
   endtask

   task automatic read_a(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
      rd_addr_a = a;
      #1;
      d = rd_data_a;
   endtask

   logic [DATA_W-1:0] rv;
   logic [DATA_W-1:0] same_cycle_exp;

   initial begin
      tests_run               = 0;
      tests_failed            = 0;
      reset                   = 1'b0;
      op_reg_write_wb         = 1'b1;
      op_reg_write_address_wb = 1'b0;
      op_res_wb               = 1'b0;
      rs_wb                   = '0;
      rd_wb                   = 3'd3;
      data_register_wb        = 16'h1234;
      memory_data_register_wb = 16'h1234;
      rd_addr_a               = '0;
      rd_addr_b               = 3'd3;

      // Reset held with a write presented: write is discarded.
      tick();
      tick();
      check_eq("reset_wb_valid", wb_valid, 0);
      check_eq("reset_count", commit_count, 0);
      check_eq("reset_wb_addr", wb_addr, 0);
      check_eq("reset_wb_data", wb_data, 0);
      check_eq("reset_port_b_r3", rd_data_b, 0);
      for (int i = 0; i < 8; i++) begin
         read_a(ADDR_W'(i), rv);
         check_eq($sformatf("reset_r%0d", i), rv, 0);
      end

      reset           = 1'b1;
      op_reg_write_wb = 1'b0;
      tick();

      // ALU writeback to rd.
      op_reg_write_wb         = 1'b1;
      op_reg_write_address_wb = 1'b0;
      op_res_wb               = 1'b0;
      rd_wb                   = 3'd5;
      rs_wb                   = 3'd2;
      data_register_wb        = 16'hBEEF;
      memory_data_register_wb = 16'h1111;
      tick();
      op_reg_write_wb = 1'b0;
      rd_addr_b       = 3'd2;
      read_a(3'd5, rv);
      check_eq("alu_r5", rv, 16'hBEEF);
      check_eq("alu_r2_untouched", rd_data_b, 0);
      check_eq("alu_wb_valid", wb_valid, 1);
      check_eq("alu_wb_addr", wb_addr, 5);
      check_eq("alu_wb_data", wb_data, 16'hBEEF);
      check_eq("alu_count", commit_count, 1);

      // Load writeback to rs.
      op_reg_write_wb         = 1'b1;
      op_reg_write_address_wb = 1'b1;
      op_res_wb               = 1'b1;
      rs_wb                   = 3'd7;
      rd_wb                   = 3'd0;
      data_register_wb        = 16'h2222;
      memory_data_register_wb = 16'hA5A5;
      tick();
      op_reg_write_wb = 1'b0;
      rd_addr_b       = 3'd0;
      read_a(3'd7, rv);
      check_eq("load_r7", rv, 16'hA5A5);
      check_eq("load_r0_untouched", rd_data_b, 0);
      check_eq("load_wb_addr", wb_addr, 7);
      check_eq("load_wb_data", wb_data, 16'hA5A5);
      check_eq("load_count", commit_count, 2);

      // Write disabled for 4 cycles.
      op_reg_write_wb         = 1'b0;
      op_reg_write_address_wb = 1'b0;
      op_res_wb               = 1'b0;
      rd_wb                   = 3'd1;
      data_register_wb        = 16'hFFFF;
      memory_data_register_wb = 16'hFFFF;
      for (int i = 0; i < 4; i++) tick();
      read_a(3'd1, rv);
      check_eq("nowr_r1", rv, 0);
      check_eq("nowr_wb_valid", wb_valid, 0);
      check_eq("nowr_wb_addr_hold", wb_addr, 7);
      check_eq("nowr_wb_data_hold", wb_data, 16'hA5A5);
      check_eq("nowr_count", commit_count, 2);

      // Same-cycle write and read of reg4.
      commit_rd(3'd4, 16'h0001);
`ifdef WB_REGFILE_BYPASS_EN
      same_cycle_exp = 16'h0002;
`else
      same_cycle_exp = 16'h0001;
`endif
      rd_addr_a               = 3'd4;
      rd_addr_b               = 3'd4;
      op_reg_write_wb         = 1'b1;
      op_reg_write_address_wb = 1'b0;
      op_res_wb               = 1'b0;
      rd_wb                   = 3'd4;
      data_register_wb        = 16'h0002;
      #1;
      check_eq("same_cyc_a", rd_data_a, same_cycle_exp);
      check_eq("same_cyc_b", rd_data_b, same_cycle_exp);
      tick();
      op_reg_write_wb = 1'b0;
      #1;
      check_eq("after_a", rd_data_a, 16'h0002);
      check_eq("after_b", rd_data_b, 16'h0002);
      check_eq("after_count", commit_count, 4);

      // Write to reg6 must not leak onto a port reading reg5, in either build.
      rd_addr_a               = 3'd5;
      op_reg_write_wb         = 1'b1;
      rd_wb                   = 3'd6;
      data_register_wb        = 16'h6666;
      #1;
      check_eq("no_fwd_other_addr", rd_data_a, 16'hBEEF);
      tick();
      op_reg_write_wb = 1'b0;
      read_a(3'd6, rv);
      check_eq("r6_written", rv, 16'h6666);

      // Register 0 is writable.
      commit_rd(3'd0, 16'h0F0F);
      read_a(3'd0, rv);
      check_eq("r0_writable", rv, 16'h0F0F);
      check_eq("r0_count", commit_count, 6);

      // X on selects with write disabled.
      op_reg_write_wb         = 1'b0;
      op_reg_write_address_wb = 1'bx;
      op_res_wb               = 1'bx;
      rs_wb                   = 'x;
      rd_wb                   = 'x;
      tick();
      read_a(3'd5, rv);
      check_eq("x_sel_r5", rv, 16'hBEEF);
      read_a(3'd7, rv);
      check_eq("x_sel_r7", rv, 16'hA5A5);
      check_eq("x_sel_count", commit_count, 6);

      // Counter wrap with 4-bit counter: 9 more commits reach 15, one more wraps to 0.
      op_reg_write_wb         = 1'b1;
      op_reg_write_address_wb = 1'b0;
      op_res_wb               = 1'b0;
      rd_wb                   = 3'd3;
      for (int i = 0; i < 9; i++) begin
         data_register_wb = DATA_W'(16'h0100 + i);
         tick();
      end
      op_reg_write_wb = 1'b0;
      check_eq("cnt_max", commit_count, 15);
      check_eq("cnt_last_data", wb_data, 16'h0108);
      commit_rd(3'd3, 16'h0200);
      check_eq("cnt_wrap", commit_count, 0);
      check_eq("cnt_wrap_valid", wb_valid, 1);

      // Reset mid-run with a write pending, then first commit right after release.
      reset           = 1'b0;
      op_reg_write_wb = 1'b1;
      rd_wb           = 3'd2;
      data_register_wb = 16'h7777;
      tick();
      check_eq("rst2_count", commit_count, 0);
      read_a(3'd5, rv);
      check_eq("rst2_r5", rv, 0);
      read_a(3'd2, rv);
      check_eq("rst2_r2", rv, 0);
      reset = 1'b1;
      tick();
      op_reg_write_wb = 1'b0;
      read_a(3'd2, rv);
      check_eq("first_commit_r2", rv, 16'h7777);
      check_eq("first_commit_count", commit_count, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
